// File: rtl/mem_bist_pkg.sv
// -----------------------------------------------------------------------------
// mem_bist_pkg : shared types and background-pattern function for mem_bist
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package mem_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_W0   = 3'd1,
    ST_R0W1 = 3'd2,
    ST_R1   = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [1:0] PAT_ZERO    = 2'd0;
  localparam logic [1:0] PAT_CHECKER = 2'd1;
  localparam logic [1:0] PAT_ADDR    = 2'd2;
  localparam logic [1:0] PAT_ONES    = 2'd3;

  // Returns the background at full 64-bit width; callers keep the low DW bits.
  function automatic logic [63:0] pattern_word(input logic [1:0] pat,
                                               input logic [63:0] addr);
    logic [63:0] w;
    w = '0;
    case (pat)
      PAT_ZERO:    w = '0;
      PAT_CHECKER: w = addr[0] ? {32{2'b10}} : {32{2'b01}};
      PAT_ADDR:    w = addr;
      default:     w = '1;
    endcase
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bist_pattern.sv
// -----------------------------------------------------------------------------
// mem_bist_pattern : combinational background generator (pattern, addr, invert)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_bist_pattern
  import mem_bist_pkg::*;
#(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic [1:0]    pattern,
  input  logic [AW-1:0] addr,
  input  logic          invert,
  output logic [DW-1:0] word
);

  logic [DW-1:0] base;

  assign base = DW'(pattern_word(pattern, 64'(addr)));
  assign word = invert ? ~base : base;

endmodule

`default_nettype wire

// File: rtl/mem_bist.sv
// -----------------------------------------------------------------------------
// mem_bist : three-pass march BIST controller for an async-read word memory
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module mem_bist
  import mem_bist_pkg::*;
#(
  parameter int AW = 15,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    pattern,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    fail_cnt,
  output logic [AW-1:0] err_addr,
  output logic [DW-1:0] err_exp,
  output logic [DW-1:0] err_got,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_d,
  output logic          mem_we,
  input  logic [DW-1:0] mem_spo
);

  localparam logic [AW-1:0] ADDR_MAX = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    pat_q, pat_d;
  logic [7:0]    fail_cnt_q, fail_cnt_d;
  logic [AW-1:0] err_addr_q, err_addr_d;
  logic [DW-1:0] err_exp_q, err_exp_d;
  logic [DW-1:0] err_got_q, err_got_d;
  logic          pass_q, pass_d;
  logic          done_q, done_d;

  logic [DW-1:0] wr_word;
  logic [DW-1:0] exp_word;
  logic          wr_inv;
  logic          exp_inv;
  logic          mismatch;

  assign wr_inv  = (state_q == ST_R0W1);
  assign exp_inv = (state_q == ST_R1);

  mem_bist_pattern #(.AW(AW), .DW(DW)) u_wr_pat (
    .pattern (pat_q),
    .addr    (addr_q),
    .invert  (wr_inv),
    .word    (wr_word)
  );

  mem_bist_pattern #(.AW(AW), .DW(DW)) u_exp_pat (
    .pattern (pat_q),
    .addr    (addr_q),
    .invert  (exp_inv),
    .word    (exp_word)
  );

  // Zero-latency read: mem_spo is valid for addr_q within the same cycle.
  assign mismatch = ((state_q == ST_R0W1) || (state_q == ST_R1)) && (mem_spo != exp_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      pat_q      <= PAT_ZERO;
      fail_cnt_q <= '0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pat_q      <= pat_d;
      fail_cnt_q <= fail_cnt_d;
      err_addr_q <= err_addr_d;
      err_exp_q  <= err_exp_d;
      err_got_q  <= err_got_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pat_d      = pat_q;
    fail_cnt_d = fail_cnt_q;
    err_addr_d = err_addr_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;
    pass_d     = pass_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_W0;
          addr_d     = '0;
          pat_d      = pattern;
          fail_cnt_d = '0;
          err_addr_d = '0;
          err_exp_d  = '0;
          err_got_d  = '0;
          pass_d     = 1'b0;
        end
      end
      ST_W0: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_MAX) begin
          state_d = ST_R0W1;
          addr_d  = '0;
        end
      end
      ST_R0W1: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_MAX) begin
          state_d = ST_R1;
          addr_d  = ADDR_MAX;
        end
      end
      ST_R1: begin
        addr_d = addr_q - 1'b1;
        if (addr_q == '0) begin
          state_d = ST_DONE;
          addr_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (mismatch) begin
      if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
      if (fail_cnt_q == 8'd0) begin
        err_addr_d = addr_q;
        err_exp_d  = exp_word;
        err_got_d  = mem_spo;
      end
    end

    // Verdict must include the compare made on the final R1 address.
    if ((state_q == ST_R1) && (addr_q == '0)) begin
      done_d = 1'b1;
      pass_d = (fail_cnt_d == 8'd0);
    end
  end

  always_comb begin
    mem_we = 1'b0;
    busy   = 1'b0;
    mem_d  = '0;
    case (state_q)
      ST_W0, ST_R0W1: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        mem_d  = wr_word;
      end
      ST_R1:   busy = 1'b1;
      default: ;
    endcase
  end

  assign mem_a    = addr_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_cnt = fail_cnt_q;
  assign err_addr = err_addr_q;
  assign err_exp  = err_exp_q;
  assign err_got  = err_got_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_bist.sv
// -----------------------------------------------------------------------------
// tb_mem_bist : randomized self-checking bench for mem_bist (AW=4 and AW=8)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_mem_bist;

  localparam int F_NONE  = 0;
  localparam int F_STUCK = 1;
  localparam int F_ALIAS = 2;
  localparam int F_CONST = 3;

  logic clk;
  logic rst_n;
  logic start4, start8;
  logic [1:0] pat_in;

  logic        busy4, done4, pass4, we4;
  logic [7:0]  fcnt4;
  logic [3:0]  ea4, a4;
  logic [15:0] ee4, eg4, d4, spo4;

  logic        busy8, done8, pass8, we8;
  logic [7:0]  fcnt8;
  logic [7:0]  ea8, a8;
  logic [15:0] ee8, eg8, d8, spo8;

  int          f_mode, f_addr, f_bit, f_val;
  logic [15:0] f_const;

  int n_chk, n_err;

  logic [15:0] mem4 [16];
  logic [15:0] mem8 [256];

  int          m_cnt, m_ea;
  logic [15:0] m_ee, m_eg;

  bit big_sel;
  logic        obs_busy, obs_done, obs_pass, obs_we;
  logic [7:0]  obs_fcnt, obs_ea, obs_a;
  logic [15:0] obs_ee, obs_eg, obs_d;

  mem_bist #(.AW(4), .DW(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .pattern(pat_in),
    .busy(busy4), .done(done4), .pass(pass4), .fail_cnt(fcnt4),
    .err_addr(ea4), .err_exp(ee4), .err_got(eg4),
    .mem_a(a4), .mem_d(d4), .mem_we(we4), .mem_spo(spo4)
  );

  mem_bist #(.AW(8), .DW(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .pattern(pat_in),
    .busy(busy8), .done(done8), .pass(pass8), .fail_cnt(fcnt8),
    .err_addr(ea8), .err_exp(ee8), .err_got(eg8),
    .mem_a(a8), .mem_d(d8), .mem_we(we8), .mem_spo(spo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int eff_addr(input int a);
    if (f_mode == F_ALIAS) return a & ~(1 << f_bit);
    return a;
  endfunction

  function automatic logic [15:0] rd_mod(input int a, input logic [15:0] raw);
    logic [15:0] m;
    m = 16'd1 << f_bit;
    if (f_mode == F_STUCK && a == f_addr) return (f_val != 0) ? (raw | m) : (raw & ~m);
    if (f_mode == F_CONST) return f_const;
    return raw;
  endfunction

  function automatic logic [15:0] pat_word(input logic [1:0] p, input int a);
    case (p)
      2'd0:    return 16'h0000;
      2'd1:    return (a % 2 == 0) ? 16'h5555 : 16'hAAAA;
      2'd2:    return 16'(a);
      default: return 16'hFFFF;
    endcase
  endfunction

  // Faulty behavioural memories: async read, write on rising edge.
  assign spo4 = rd_mod(int'(a4), mem4[eff_addr(int'(a4))]);
  assign spo8 = rd_mod(int'(a8), mem8[eff_addr(int'(a8))]);

  always @(posedge clk) begin
    if (we4) mem4[eff_addr(int'(a4))] <= d4;
    if (we8) mem8[eff_addr(int'(a8))] <= d8;
  end

  assign obs_busy = big_sel ? busy8 : busy4;
  assign obs_done = big_sel ? done8 : done4;
  assign obs_pass = big_sel ? pass8 : pass4;
  assign obs_we   = big_sel ? we8   : we4;
  assign obs_fcnt = big_sel ? fcnt8 : fcnt4;
  assign obs_ea   = big_sel ? ea8   : {4'b0, ea4};
  assign obs_a    = big_sel ? a8    : {4'b0, a4};
  assign obs_ee   = big_sel ? ee8   : ee4;
  assign obs_eg   = big_sel ? eg8   : eg4;
  assign obs_d    = big_sel ? d8    : d4;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_cmp(input int a, input logic [15:0] e, input logic [15:0] g);
    if (g !== e) begin
      if (m_cnt == 0) begin
        m_ea = a;
        m_ee = e;
        m_eg = g;
      end
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  // March test stated directly: write P up, read P / write ~P up, read ~P down.
  task automatic model_run(input int aw, input logic [1:0] p);
    logic [15:0] m [256];
    int n;
    n = 1 << aw;
    m_cnt = 0; m_ea = 0; m_ee = '0; m_eg = '0;
    for (int a = 0; a < n; a++) m[eff_addr(a)] = pat_word(p, a);
    for (int a = 0; a < n; a++) begin
      model_cmp(a, pat_word(p, a), rd_mod(a, m[eff_addr(a)]));
      m[eff_addr(a)] = ~pat_word(p, a);
    end
    for (int a = n - 1; a >= 0; a--) model_cmp(a, ~pat_word(p, a), rd_mod(a, m[eff_addr(a)]));
  endtask

  task automatic run_test(input bit big, input logic [1:0] p, input bit poke_w0);
    int n, cyc, busy_cyc, wr_cyc, done_cyc;
    n = big ? 256 : 16;
    big_sel = big;
    model_run(big ? 8 : 4, p);
    @(negedge clk);
    pat_in = p;
    if (big) start8 = 1'b1; else start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0; start8 = 1'b0;
    pat_in = 2'(~p);
    cyc = 0; busy_cyc = 0; wr_cyc = 0; done_cyc = -1;
    while (done_cyc < 0 && cyc < 4 * n + 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check_val("pass_cleared", 32'(obs_pass), 32'd0);
      if (obs_busy) busy_cyc++;
      if (obs_we) wr_cyc++;
      if (obs_done) done_cyc = cyc;
      if (poke_w0 && cyc == 5) begin
        if (big) start8 = 1'b1; else start4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0; start8 = 1'b0;
      end
    end
    check_val("done_cycle", 32'(done_cyc), 32'(3 * n + 1));
    check_val("busy_cycles", 32'(busy_cyc), 32'(3 * n));
    check_val("write_cycles", 32'(wr_cyc), 32'(2 * n));
    check_val("busy_at_done", 32'(obs_busy), 32'd0);
    check_val("pass", 32'(obs_pass), 32'(m_cnt == 0));
    check_val("fail_cnt", 32'(obs_fcnt), 32'(m_cnt));
    check_val("err_addr", 32'(obs_ea), 32'(m_ea));
    check_val("err_exp", 32'(obs_ee), 32'(m_ee));
    check_val("err_got", 32'(obs_eg), 32'(m_eg));
    @(negedge clk);
    check_val("done_pulse_len", 32'(obs_done), 32'd0);
    check_val("pass_held", 32'(obs_pass), 32'(m_cnt == 0));
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0; pat_in = 2'd0;
    big_sel = 1'b0;
    f_mode = F_NONE; f_addr = 0; f_bit = 0; f_val = 0; f_const = 16'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_busy", 32'(busy4), 32'd0);
    check_val("rst_done", 32'(done4), 32'd0);
    check_val("rst_pass", 32'(pass4), 32'd0);
    check_val("rst_fail_cnt", 32'(fcnt4), 32'd0);
    check_val("rst_mem_we", 32'(we4), 32'd0);
    check_val("rst_mem_a", 32'(a4), 32'd0);
    check_val("rst_err_exp", 32'(ee4), 32'd0);
    check_val("rst8_busy", 32'(busy8), 32'd0);

    // Fault-free checkerboard, with an ignored start during W0.
    run_test(1'b0, 2'd1, 1'b1);
    check_val("clean_pass", 32'(pass4), 32'd1);

    // Bit 3 of address 6 stuck at 0, starting from DONE.
    f_mode = F_STUCK; f_addr = 6; f_bit = 3; f_val = 0;
    run_test(1'b0, 2'd0, 1'b0);
    check_val("stuck_cnt", 32'(fcnt4), 32'd1);
    check_val("stuck_addr", 32'(ea4), 32'h6);
    check_val("stuck_got", 32'(eg4), 32'hFFF7);

    // Address bit 2 ignored by the memory.
    f_mode = F_ALIAS; f_bit = 2;
    run_test(1'b0, 2'd2, 1'b0);
    check_val("alias_got", 32'(eg4), 32'h0004);

    // Memory returns a constant: saturation on the AW=8 instance.
    f_mode = F_CONST; f_const = 16'h1234;
    run_test(1'b1, 2'd0, 1'b0);
    check_val("sat_cnt", 32'(fcnt8), 32'd255);

    for (int i = 0; i < 8; i++) begin
      bit big;
      int aw;
      big = ($urandom_range(0, 3) == 0);
      aw = big ? 8 : 4;
      f_mode  = $urandom_range(0, 3);
      f_addr  = $urandom_range(0, (1 << aw) - 1);
      f_bit   = (f_mode == F_ALIAS) ? $urandom_range(0, aw - 1) : $urandom_range(0, 15);
      f_val   = $urandom_range(0, 1);
      f_const = 16'($urandom);
      run_test(big, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of R0W1.
    big_sel = 1'b0;
    f_mode = F_ALIAS; f_bit = 2;
    @(negedge clk);
    pat_in = 2'd2; start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    repeat (19) @(negedge clk);
    check_val("pre_rst_we", 32'(we4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_mem_we", 32'(we4), 32'd0);
    check_val("arst_busy", 32'(busy4), 32'd0);
    check_val("arst_fail_cnt", 32'(fcnt4), 32'd0);
    check_val("arst_err_addr", 32'(ea4), 32'd0);
    check_val("arst_err_got", 32'(eg4), 32'd0);
    check_val("arst_mem_a", 32'(a4), 32'd0);
    check_val("arst_mem_d", 32'(d4), 32'd0);
    @(negedge clk);
    check_val("arst_hold_we", 32'(we4), 32'd0);
    rst_n = 1'b1;
    f_mode = F_NONE;
    run_test(1'b0, 2'($urandom_range(0, 3)), 1'b0);
    check_val("post_rst_pass", 32'(pass4), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
